// File: rtl/user_pulser_seq.sv
// user_pulser_seq: program FIFO and launch sequencer for the user pulse generator.
// Optional replay of retired programs: define USER_PULSER_SEQ_LOOP_EN.
module user_pulser_seq #(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [7:0]              cfg_f1_cnt_i,
    input  logic [7:0]              cfg_f2_cnt_i,
    input  logic [7:0]              cfg_stop_cnt_i,
    input  logic [15:0]             cfg_f1_end_i,
    input  logic [15:0]             cfg_f1_switch_i,
    input  logic [15:0]             cfg_f2_end_i,
    input  logic [15:0]             cfg_f2_switch_i,

    input  logic                    enable_i,
    input  logic                    abort_i,
    input  logic                    loop_i,
    input  logic [2:0]              pulser_state_i,

    output logic                    start_o,
    output logic                    stop_o,
    output logic [7:0]              f1_cnt_o,
    output logic [7:0]              f2_cnt_o,
    output logic [7:0]              stop_cnt_o,
    output logic [15:0]             f1_end_o,
    output logic [15:0]             f1_switch_o,
    output logic [15:0]             f2_end_o,
    output logic [15:0]             f2_switch_o,

    output logic                    busy_o,
    output logic                    done_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 88;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [2:0] PS_IDLE = 3'd0;
    localparam logic [2:0] PS_DONE = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] cfg_word;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] head;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    state_t state;
    state_t state_d;

    logic start_d;
    logic busy_d;
    logic done_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic replay;
    logic launch;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // Retirement happens only when the generator reports DONE while we wait on it.
    assign pop = (state == S_WAIT)
               & (pulser_state_i == PS_DONE)
               & !abort_i;

`ifdef USER_PULSER_SEQ_LOOP_EN
    assign replay = pop & loop_i;
`else
    logic unused_loop;
    assign unused_loop = loop_i;
    assign replay      = 1'b0;
`endif

    // Replay owns the write port in a retirement cycle, so user pushes back off.
    assign cfg_ready_o = !full & !abort_i & !replay;
    assign push        = cfg_valid_i & cfg_ready_o;

    assign launch = !empty
                  & enable_i
                  & (pulser_state_i == PS_IDLE)
                  & !stop_o
                  & !abort_i;

    assign cfg_word = {
        cfg_f1_cnt_i,
        cfg_f2_cnt_i,
        cfg_stop_cnt_i,
        cfg_f1_end_i,
        cfg_f1_switch_i,
        cfg_f2_end_i,
        cfg_f2_switch_i
    };

    assign wr_data = replay ? head : cfg_word;

    // Head stays put until retirement, so parameters are stable for the whole run.
    assign head = empty ? '0 : mem[rd_ptr];

    assign f1_cnt_o    = head[87:80];
    assign f2_cnt_o    = head[79:72];
    assign stop_cnt_o  = head[71:64];
    assign f1_end_o    = head[63:48];
    assign f1_switch_o = head[47:32];
    assign f2_end_o    = head[31:16];
    assign f2_switch_o = head[15:0];

    assign level_o = level;

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk_i) begin
        if (push | replay) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; abort flushes everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push | replay) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop & !replay})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sequencer state and registered control strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            stop_o  <= 1'b0;
        end else begin
            state   <= state_d;
            start_o <= start_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
            stop_o  <= abort_i;
        end
    end

    // Next-state decode; abort overrides issue and retirement.
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
    end

endmodule
